// File: rtl/fetch_unit_if.sv
// fetch_unit_if: control/status bundle between the fetch unit and its decoder/ALU side
//   start_i/start_addr_i    : launch a program at an address
//   branch_en_i/cond_met_i/target_i/load_inst_i/ack_i : decoder/ALU info for the current instruction
//   prog_ctr_o/instr_valid_o/busy_o/done_o             : fetch status
//   instr_count_o/cycle_count_o                        : saturating performance counters
interface fetch_unit_if #(parameter int PC_W = 10, parameter int CNT_W = 16);
  logic             start_i;
  logic [PC_W-1:0]  start_addr_i;
  logic             branch_en_i;
  logic             cond_met_i;
  logic [PC_W-1:0]  target_i;
  logic             load_inst_i;
  logic             ack_i;
  logic [PC_W-1:0]  prog_ctr_o;
  logic             instr_valid_o;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] instr_count_o;
  logic [CNT_W-1:0] cycle_count_o;
  modport master (
    output start_i, start_addr_i, branch_en_i, cond_met_i, target_i, load_inst_i, ack_i,
    input  prog_ctr_o, instr_valid_o, busy_o, done_o, instr_count_o, cycle_count_o
  );
  modport slave (
    input  start_i, start_addr_i, branch_en_i, cond_met_i, target_i, load_inst_i, ack_i,
    output prog_ctr_o, instr_valid_o, busy_o, done_o, instr_count_o, cycle_count_o
  );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: program counter sequencer with load stall, branches and saturating perf counters
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : fetch_unit_if slave (start/decoder inputs, pc/status/counter outputs)
module fetch_unit #(
  parameter int PC_W  = 10,
  parameter int CNT_W = 16
) (
  input logic        clk,
  input logic        rst_n,
  fetch_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, LOADWAIT, DONE} state_t;
  state_t           state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [CNT_W-1:0] ic_q, ic_d, cc_q, cc_d;
  logic             clr, ic_inc, cc_inc;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    clr     = 1'b0;
    ic_inc  = 1'b0;
    cc_inc  = 1'b0;
    case (state_q)
      IDLE, DONE: if (bus.start_i) begin
        pc_d    = bus.start_addr_i;
        clr     = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        cc_inc = 1'b1;
        if (bus.ack_i) begin
          ic_inc  = 1'b1;
          state_d = DONE;
        end else if (bus.load_inst_i) begin
          state_d = LOADWAIT;
        end else begin
          ic_inc = 1'b1;
          pc_d   = (bus.branch_en_i && bus.cond_met_i) ? bus.target_i : pc_q + 1'b1;
        end
      end
      default: begin
        cc_inc  = 1'b1;
        ic_inc  = 1'b1;
        pc_d    = pc_q + 1'b1;
        state_d = RUN;
      end
    endcase
    ic_d = clr ? '0 : (ic_inc && ic_q != {CNT_W{1'b1}}) ? ic_q + 1'b1 : ic_q;
    cc_d = clr ? '0 : (cc_inc && cc_q != {CNT_W{1'b1}}) ? cc_q + 1'b1 : cc_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ic_q    <= '0;
      cc_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ic_q    <= ic_d;
      cc_q    <= cc_d;
    end
  end
  assign bus.prog_ctr_o    = pc_q;
  assign bus.instr_valid_o = state_q == RUN;
  assign bus.busy_o        = state_q == RUN || state_q == LOADWAIT;
  assign bus.done_o        = state_q == DONE;
  assign bus.instr_count_o = ic_q;
  assign bus.cycle_count_o = cc_q;
endmodule
